// File: rtl/key_scan_if.sv
// Keypad pin and key-event bundle for key_scan.
//   key_row   : row drive, active-low, one row low at a time (scanner -> pins)
//   key_col   : column sense, active-low, asynchronous (pins -> scanner)
//   key_code  : code of last accepted key, row*4+col (scanner -> app)
//   key_valid : one-cycle pulse per accepted press (scanner -> app)
//   key_down  : held from acceptance until release is debounced (scanner -> app)
// master = scanner side, slave = keypad/application side.
interface key_scan_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output key_row, key_code, key_valid, key_down,
    input  key_col
  );

  modport slave (
    input  key_row, key_code, key_valid, key_down,
    output key_col
  );
endinterface

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner.
// Drives rows low one at a time, samples the synchronized columns at the end
// of each row slot, builds a 16-bit frame (set bit = pressed) and debounces
// whole frames: a press is accepted after DEBOUNCE_FRAMES consecutive frames
// with the same single key, a release after DEBOUNCE_FRAMES empty frames.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   kif : key_scan_if.master (rows out, cols in, key event outputs)
module key_scan #(
  parameter int unsigned SYSCLK          = 50000000,
  parameter int unsigned ROW_FREQ        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic          clk,
  input  logic          rst,
  key_scan_if.master    kif
);

  localparam int unsigned ROW_COUNT = SYSCLK / ROW_FREQ - 1;
  localparam int          CW        = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI}  cls_t;

  logic [3:0]  col_s1, col_sync;
  logic [31:0] scan_time;
  logic [1:0]  row_idx;
  logic [3:0]  row_q;
  logic [15:0] frame;
  // [0] = frame_done (frame complete), [1] = frame class registered
  logic [1:0]  vld_pipe;
  logic        frame_done;
  logic        row_end;

  cls_t        cls_c, cls_q;
  logic [3:0]  key_c, key_q;
  logic [4:0]  n_set;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]  cand, cand_nxt;
  logic [3:0]  code_q, code_nxt;
  logic        valid_q, valid_nxt;
  logic        down_q, down_nxt;

  assign row_end    = (scan_time == ROW_COUNT);
  assign frame_done = vld_pipe[0];

  assign kif.key_row   = row_q;
  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.key_down  = down_q;

  // Scan timer, row drive, column sync and frame capture. Sampling at the last
  // cycle of the row slot gives the drive flop, the two-flop synchronizer and
  // the board wiring ample time to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1    <= 4'hF;
      col_sync  <= 4'hF;
      scan_time <= '0;
      row_idx   <= '0;
      row_q     <= 4'b1111;
      frame     <= '0;
      vld_pipe  <= '0;
    end else begin
      col_s1   <= kif.key_col;
      col_sync <= col_s1;
      row_q    <= ~(4'b0001 << row_idx);
      if (row_end) begin
        scan_time                   <= '0;
        row_idx                     <= row_idx + 2'd1;
        frame[{row_idx, 2'b00} +: 4] <= ~col_sync;
      end else begin
        scan_time <= scan_time + 32'd1;
      end
      vld_pipe <= {vld_pipe[0], row_end && (row_idx == 2'd3)};
    end
  end

  // Frame classification: count set bits; the index is only meaningful
  // when exactly one bit is set.
  always_comb begin
    n_set = '0;
    key_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_set = n_set + 5'd1;
        key_c = 4'(i);
      end
    end
    if (n_set == 5'd0)      cls_c = CLS_NONE;
    else if (n_set == 5'd1) cls_c = CLS_SINGLE;
    else                    cls_c = CLS_MULTI;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q <= CLS_NONE;
      key_q <= '0;
    end else if (frame_done) begin
      cls_q <= cls_c;
      key_q <= key_c;
    end
  end

  // Debounce FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cand    <= cand_nxt;
      code_q  <= code_nxt;
      valid_q <= valid_nxt;
      down_q  <= down_nxt;
    end
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = code_q;
    valid_nxt = 1'b0;
    down_nxt  = down_q;
    if (vld_pipe[1]) begin
      case (state)
        IDLE: begin
          if (cls_q == CLS_SINGLE) begin
            cand_nxt  = key_q;
            cnt_nxt   = CW'(1);
            state_nxt = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (cls_q == CLS_SINGLE && key_q == cand) begin
            if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
              code_nxt  = cand;
              valid_nxt = 1'b1;
              down_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        HELD: begin
          // Other keys while held are ignored: no auto-repeat, no rollover.
          if (cls_q == CLS_NONE) begin
            cnt_nxt   = CW'(1);
            state_nxt = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (cls_q == CLS_NONE) begin
            if (cnt_inc == CW'(DEBOUNCE_FRAMES)) begin
              down_nxt  = 1'b0;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan.sv
module tb_key_scan;
  localparam int DB    = 3;
  localparam int FRAME = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_scan_if kif();

  key_scan #(.SYSCLK(1000), .ROW_FREQ(100), .DEBOUNCE_FRAMES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  // Keypad: a pressed key (r,c) pulls col c low while row r is driven low
  logic [15:0] keys = '0;
  logic [3:0]  col_v;
  always_comb begin
    col_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.key_row[r]) col_v[c] = 1'b0;
  end
  assign kif.key_col = col_v;

  int cyc;
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         fall;
    logic [3:0] code;
  } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int checks   = 0;
  int failures = 0;

  // Observed events: key_valid pulses and key_down falling edges
  logic mon_down = 1'b0;
  ev_t  mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_down = 1'b0;
    end else begin
      if (kif.key_valid === 1'b1) begin
        mon_e.cyc = cyc; mon_e.fall = 1'b0; mon_e.code = kif.key_code;
        obs_q.push_back(mon_e);
      end
      if (mon_down && kif.key_down !== 1'b1) begin
        mon_e.cyc = cyc; mon_e.fall = 1'b1; mon_e.code = 4'h0;
        obs_q.push_back(mon_e);
      end
      mon_down = (kif.key_down === 1'b1);
    end
  end

  // Reference model: per-frame rules on the key set held during that frame
  int         fidx;
  bit         m_held;
  int         m_run;
  logic [3:0] m_key;
  int         m_empty;
  logic [3:0] m_code;
  bit         m_down_prev;

  task automatic model_reset();
    fidx = 0; m_held = 0; m_run = 0; m_key = '0; m_empty = 0; m_code = '0;
    m_down_prev = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Apply key set k for one whole frame; returns just after the frame's last edge
  task automatic frame(input logic [15:0] k);
    ev_t e;
    int  n, idx;
    keys = k;
    m_down_prev = m_held;
    n = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && idx[3:0] == m_key) m_run++;
      else if (n == 1 && m_run == 0) begin m_key = idx[3:0]; m_run = 1; end
      else m_run = 0;
      if (m_run == DB) begin
        m_held = 1; m_run = 0; m_empty = 0; m_code = m_key;
        e.cyc = FRAME*(fidx+1) + 2; e.fall = 1'b0; e.code = m_key;
        exp_q.push_back(e);
      end
    end else begin
      if (n == 0) begin
        m_empty++;
        if (m_empty == DB) begin
          m_held = 0; m_empty = 0;
          e.cyc = FRAME*(fidx+1) + 2; e.fall = 1'b1; e.code = 4'h0;
          exp_q.push_back(e);
        end
      end else begin
        m_empty = 0;
      end
    end
    repeat (FRAME) @(posedge clk);
    #1;
    fidx++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    keys = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Compare expected events that should have happened by now with observed ones
  function automatic string ev_diff();
    ev_t e, o;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0)
        return $sformatf("got nothing, want %s@%0d code %0h",
                         e.fall ? "fall" : "pulse", e.cyc, e.code);
      o = obs_q.pop_front();
      if (o.cyc != e.cyc || o.fall != e.fall || o.code !== e.code)
        return $sformatf("got %s@%0d code %0h, want %s@%0d code %0h",
                         o.fall ? "fall" : "pulse", o.cyc, o.code,
                         e.fall ? "fall" : "pulse", e.cyc, e.code);
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      return $sformatf("got extra %s@%0d code %0h, want none",
                       o.fall ? "fall" : "pulse", o.cyc, o.code);
    end
    return "";
  endfunction

  task automatic test_reset();
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_row;
    rst = 1'b0;
    keys = '0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (kif.key_row !== 4'b1111) begin failures++; $display("FAIL reset_row: got %b want 1111", kif.key_row); end
    checks++; if (kif.key_code !== 4'h0) begin failures++; $display("FAIL reset_code: got %h want 0", kif.key_code); end
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", kif.key_valid); end
    checks++; if (kif.key_down !== 1'b0) begin failures++; $display("FAIL reset_down: got %b want 0", kif.key_down); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      exp_row = ~(one << (((cyc - 1) / 10) % 4));
      checks++;
      if (kif.key_row !== exp_row) begin
        failures++;
        $display("FAIL row_scan cyc %0d: got %b want %b", cyc, kif.key_row, exp_row);
      end
    end
  endtask

  task automatic test_press();
    string s;
    apply_reset();
    for (int f = 0; f < 12; f++) begin
      frame(16'h0200);
      checks++;
      if (kif.key_down !== m_down_prev) begin
        failures++; $display("FAIL press_down frame %0d: got %b want %b", f, kif.key_down, m_down_prev);
      end
    end
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL press_events: %s", s); end
    checks++; if (kif.key_code !== 4'd9) begin failures++; $display("FAIL press_code: got %0d want 9", kif.key_code); end
    checks++; if (kif.key_down !== 1'b1) begin failures++; $display("FAIL press_held: got %b want 1", kif.key_down); end
  endtask

  task automatic test_release_glitch();
    string s;
    frame(16'h0000);
    frame(16'h0200);
    checks++; if (kif.key_down !== 1'b1) begin failures++; $display("FAIL glitch_down: got %b want 1", kif.key_down); end
    for (int f = 0; f < 3; f++) frame(16'h0000);
    checks++; if (kif.key_down !== 1'b1) begin failures++; $display("FAIL release_early: got %b want 1", kif.key_down); end
    frame(16'h0000);
    checks++; if (kif.key_down !== 1'b0) begin failures++; $display("FAIL release_down: got %b want 0", kif.key_down); end
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL release_events: %s", s); end
  endtask

  task automatic test_bounce();
    string s;
    for (int i = 0; i < 5; i++) begin
      frame(16'h0200);
      frame(16'h0200);
      frame(16'h0000);
      checks++;
      if (kif.key_down !== 1'b0) begin failures++; $display("FAIL bounce_down iter %0d: got %b want 0", i, kif.key_down); end
    end
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL bounce_events: %s", s); end
  endtask

  task automatic test_multi();
    string s;
    for (int i = 0; i < 5; i++) frame(16'h0021);
    frame(16'h0000);
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL multi_events: %s", s); end
    checks++; if (kif.key_code !== m_code) begin failures++; $display("FAIL multi_code: got %0d want %0d", kif.key_code, m_code); end
    checks++; if (kif.key_down !== 1'b0) begin failures++; $display("FAIL multi_down: got %b want 0", kif.key_down); end
  endtask

  task automatic test_random();
    string       s;
    logic [15:0] one16 = 16'h0001;
    logic [15:0] cur;
    logic [15:0] k;
    int          r;
    cur = one16 << $urandom_range(0, 15);
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r <= 1)      k = '0;
      else if (r <= 6) k = cur;
      else if (r == 7) begin cur = one16 << $urandom_range(0, 15); k = cur; end
      else if (r == 8) k = cur | (one16 << $urandom_range(0, 15));
      else             k = 16'($urandom());
      frame(k);
      checks++;
      if (kif.key_down !== m_down_prev) begin
        failures++; $display("FAIL random_down frame %0d: got %b want %b", f, kif.key_down, m_down_prev);
      end
    end
    frame(16'h0000);
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL random_events: %s", s); end
    checks++; if (kif.key_code !== m_code) begin failures++; $display("FAIL random_code: got %0d want %0d", kif.key_code, m_code); end
  endtask

  task automatic test_reset_mid();
    string       s;
    logic [15:0] one16 = 16'h0001;
    logic [3:0]  kc;
    logic [15:0] k;
    kc = 4'($urandom_range(1, 15));
    k  = one16 << kc;
    apply_reset();
    frame(k);
    frame(k);
    keys = k;
    repeat (17) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (kif.key_row !== 4'b1111) begin failures++; $display("FAIL mid_row: got %b want 1111", kif.key_row); end
    checks++; if (kif.key_code !== 4'h0) begin failures++; $display("FAIL mid_code: got %h want 0", kif.key_code); end
    checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", kif.key_valid); end
    checks++; if (kif.key_down !== 1'b0) begin failures++; $display("FAIL mid_down: got %b want 0", kif.key_down); end
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL mid_pre_events: %s", s); end
    apply_reset();
    frame(k);
    frame(k);
    frame(k);
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL mid_restart_early: %s", s); end
    checks++; if (kif.key_down !== 1'b0) begin failures++; $display("FAIL mid_restart_down: got %b want 0", kif.key_down); end
    frame(k);
    s = ev_diff();
    checks++; if (s != "") begin failures++; $display("FAIL mid_restart_events: %s", s); end
    checks++; if (kif.key_code !== kc) begin failures++; $display("FAIL mid_restart_code: got %0d want %0d", kif.key_code, kc); end
    checks++; if (kif.key_down !== 1'b1) begin failures++; $display("FAIL mid_restart_held: got %b want 1", kif.key_down); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release_glitch();
    test_bounce();
    test_multi();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
